// File: rtl/wdt_apb.sv
// wdt_apb: APB watchdog timer; first timeout raises WDTIntr, second timeout or a bad feed pulses WDTReset.
module wdt_apb #(
  parameter int XLEN     = 64,
  parameter int RSTPULSE = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic [7:0]        PADDR,
  input  logic [XLEN-1:0]   PWDATA,
  input  logic [XLEN/8-1:0] PSTRB,
  input  logic              PWRITE,
  input  logic              PENABLE,
  output logic [XLEN-1:0]   PRDATA,
  output logic              PREADY,
  output logic              WDTIntr,
  output logic              WDTReset
);
  localparam logic [31:0] FEED_KEY   = 32'h5A5AA5A5;
  localparam logic [31:0] UNLOCK_KEY = 32'h1ACCE551;
  localparam int PW = $clog2(RSTPULSE + 1);
  typedef enum logic [1:0] {IDLE, STAGE1, STAGE2, RSTOUT} state_t;
  state_t r_state, w_state_nxt;
  logic          r_en, r_rsten, r_irq, r_rc, r_locked;
  logic [3:0]    r_presc;
  logic [31:0]   r_load, r_count, w_count_nxt;
  logic [15:0]   r_pcnt, w_pcnt_nxt;
  logic [PW-1:0] r_pulse;
  logic [31:0]   w_wdata, w_rd;
  logic [3:0]    w_strb;
  logic [5:0]    w_off;
  logic          w_wr, w_wr_ctrl, w_wr_load, w_wr_feed, w_wr_stat, w_wr_lock;
  logic          w_en_nxt, w_feed, w_feed_ok, w_feed_bad, w_tick, w_irq_set, w_rc_set;
  logic          w_unused;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    merge = o;
    for (int i = 0; i < 4; i++) if (s[i]) merge[8*i +: 8] = n[8*i +: 8];
  endfunction
  // 64-bit bus: PADDR[2] picks which 32-bit lane carries the register
  generate
    if (XLEN == 64) begin : g_l64
      assign w_wdata = PADDR[2] ? PWDATA[63:32] : PWDATA[31:0];
      assign w_strb  = PADDR[2] ? PSTRB[7:4] : PSTRB[3:0];
    end else begin : g_l32
      assign w_wdata = PWDATA[31:0];
      assign w_strb  = PSTRB[3:0];
    end
  endgenerate
  assign w_unused   = ^PADDR[1:0];
  assign w_off      = PADDR[7:2];
  assign w_wr       = PSEL & PWRITE & PENABLE;
  assign w_wr_ctrl  = w_wr && w_off == 6'd0 && !r_locked;
  assign w_wr_load  = w_wr && w_off == 6'd1 && !r_locked;
  assign w_wr_feed  = w_wr && w_off == 6'd3;
  assign w_wr_stat  = w_wr && w_off == 6'd4;
  assign w_wr_lock  = w_wr && w_off == 6'd5;
  assign w_en_nxt   = (w_wr_ctrl && w_strb[0]) ? w_wdata[0] : r_en;
  assign w_feed     = w_wr_feed && (r_state == STAGE1 || r_state == STAGE2);
  assign w_feed_ok  = w_feed && w_strb == 4'hF && w_wdata == FEED_KEY;
  assign w_feed_bad = w_feed && !w_feed_ok;
  assign w_tick     = r_state != IDLE && r_pcnt == (16'd1 << r_presc) - 16'd1;
  // priority: EN clear > feed > tick
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_irq_set   = 1'b0;
    w_rc_set    = 1'b0;
    if (r_state == IDLE) begin
      if (w_en_nxt) begin
        w_state_nxt = STAGE1;
        w_count_nxt = r_load;
      end
    end else if (!w_en_nxt) begin
      w_state_nxt = IDLE;
    end else if (r_state == RSTOUT) begin
      if (r_pulse == PW'(RSTPULSE - 1)) begin
        w_state_nxt = STAGE1;
        w_count_nxt = r_load;
      end
    end else if (w_feed_ok) begin
      w_state_nxt = STAGE1;
      w_count_nxt = r_load;
    end else if (w_feed_bad && r_rsten) begin
      w_state_nxt = RSTOUT;
      w_rc_set    = 1'b1;
    end else if (w_tick) begin
      if (r_count != 32'd0) begin
        w_count_nxt = r_count - 32'd1;
      end else if (r_state == STAGE2 && r_rsten) begin
        w_state_nxt = RSTOUT;
        w_rc_set    = 1'b1;
      end else begin
        w_state_nxt = STAGE2;
        w_count_nxt = r_load;
        w_irq_set   = 1'b1;
      end
    end
    w_pcnt_nxt = (w_feed_ok || w_state_nxt != r_state) ? 16'd0 :
                 (r_state == IDLE) ? r_pcnt :
                 w_tick ? 16'd0 : r_pcnt + 16'd1;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= IDLE;
      r_en     <= 1'b0;
      r_rsten  <= 1'b0;
      r_presc  <= 4'd0;
      r_load   <= 32'hFFFFFFFF;
      r_count  <= 32'hFFFFFFFF;
      r_pcnt   <= 16'd0;
      r_pulse  <= '0;
      r_irq    <= 1'b0;
      r_rc     <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_en     <= w_en_nxt;
      r_rsten  <= (w_wr_ctrl && w_strb[0]) ? w_wdata[1] : r_rsten;
      r_presc  <= (w_wr_ctrl && w_strb[1]) ? w_wdata[11:8] : r_presc;
      r_load   <= w_wr_load ? merge(r_load, w_wdata, w_strb) : r_load;
      r_count  <= w_count_nxt;
      r_pcnt   <= w_pcnt_nxt;
      r_pulse  <= (r_state == RSTOUT && w_state_nxt == RSTOUT) ? r_pulse + PW'(1) : '0;
      r_irq    <= w_irq_set | (r_irq & ~(w_wr_stat & w_strb[0] & w_wdata[0]));
      r_rc     <= w_rc_set | (r_rc & ~(w_wr_stat & w_strb[0] & w_wdata[1]));
      r_locked <= w_wr_lock ? (w_wdata != UNLOCK_KEY) : r_locked;
    end
  end
  assign w_rd = (w_off == 6'd0) ? {20'd0, r_presc, 6'd0, r_rsten, r_en} :
                (w_off == 6'd1) ? r_load :
                (w_off == 6'd2) ? r_count :
                (w_off == 6'd4) ? {27'd0, r_locked, r_state, r_rc, r_irq} : 32'd0;
  assign PRDATA   = {(XLEN/32){w_rd}};
  assign PREADY   = 1'b1;
  assign WDTIntr  = r_irq;
  assign WDTReset = r_state == RSTOUT;
endmodule
